// File: rtl/alu_dec_mc_pkg.sv
// Shared instruction defines: opcodes, functs, ALUOP codes and mult/div types.
package alu_dec_mc_pkg;

   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LB     = 6'h20;
   localparam logic [5:0] OP_LH     = 6'h21;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_LBU    = 6'h24;
   localparam logic [5:0] OP_LHU    = 6'h25;
   localparam logic [5:0] OP_SB     = 6'h28;
   localparam logic [5:0] OP_SH     = 6'h29;
   localparam logic [5:0] OP_SW     = 6'h2B;

   localparam logic [5:0] FN_SLL   = 6'h00;
   localparam logic [5:0] FN_SRL   = 6'h02;
   localparam logic [5:0] FN_SRA   = 6'h03;
   localparam logic [5:0] FN_SLLV  = 6'h04;
   localparam logic [5:0] FN_SRLV  = 6'h06;
   localparam logic [5:0] FN_SRAV  = 6'h07;
   localparam logic [5:0] FN_JR    = 6'h08;
   localparam logic [5:0] FN_JALR  = 6'h09;
   localparam logic [5:0] FN_MFHI  = 6'h10;
   localparam logic [5:0] FN_MTHI  = 6'h11;
   localparam logic [5:0] FN_MFLO  = 6'h12;
   localparam logic [5:0] FN_MTLO  = 6'h13;
   localparam logic [5:0] FN_MULT  = 6'h18;
   localparam logic [5:0] FN_MULTU = 6'h19;
   localparam logic [5:0] FN_DIV   = 6'h1A;
   localparam logic [5:0] FN_DIVU  = 6'h1B;
   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_ADDU  = 6'h21;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SUBU  = 6'h23;
   localparam logic [5:0] FN_AND   = 6'h24;
   localparam logic [5:0] FN_OR    = 6'h25;
   localparam logic [5:0] FN_XOR   = 6'h26;
   localparam logic [5:0] FN_NOR   = 6'h27;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_SLTU  = 6'h2B;

   localparam logic [7:0] ALUOP_NOP   = 8'd0;
   localparam logic [7:0] ALUOP_ADD   = 8'd1;
   localparam logic [7:0] ALUOP_ADDU  = 8'd2;
   localparam logic [7:0] ALUOP_SUB   = 8'd3;
   localparam logic [7:0] ALUOP_SUBU  = 8'd4;
   localparam logic [7:0] ALUOP_AND   = 8'd5;
   localparam logic [7:0] ALUOP_OR    = 8'd6;
   localparam logic [7:0] ALUOP_XOR   = 8'd7;
   localparam logic [7:0] ALUOP_NOR   = 8'd8;
   localparam logic [7:0] ALUOP_SLT   = 8'd9;
   localparam logic [7:0] ALUOP_SLTU  = 8'd10;
   localparam logic [7:0] ALUOP_SLL   = 8'd11;
   localparam logic [7:0] ALUOP_SRL   = 8'd12;
   localparam logic [7:0] ALUOP_SRA   = 8'd13;
   localparam logic [7:0] ALUOP_SLLV  = 8'd14;
   localparam logic [7:0] ALUOP_SRLV  = 8'd15;
   localparam logic [7:0] ALUOP_SRAV  = 8'd16;
   localparam logic [7:0] ALUOP_LUI   = 8'd17;
   localparam logic [7:0] ALUOP_MULT  = 8'd18;
   localparam logic [7:0] ALUOP_MULTU = 8'd19;
   localparam logic [7:0] ALUOP_DIV   = 8'd20;
   localparam logic [7:0] ALUOP_DIVU  = 8'd21;
   localparam logic [7:0] ALUOP_MFHI  = 8'd22;
   localparam logic [7:0] ALUOP_MFLO  = 8'd23;
   localparam logic [7:0] ALUOP_MTHI  = 8'd24;
   localparam logic [7:0] ALUOP_MTLO  = 8'd25;

   typedef enum logic [1:0] {MdMult, MdMultu, MdDiv, MdDivu} md_op_e;

   typedef enum logic [1:0] {SeqIdle, SeqBusy, SeqDone} seq_state_e;

   // MULT..DIVU functs are consecutive, so the low two bits give the kind.
   function automatic md_op_e md_kind(logic [5:0] funct);
      return md_op_e'(funct[1:0]);
   endfunction

endpackage

// File: rtl/alu_dec_mc_flopenrc.sv
// Team enable/clear flip-flop: async active-low reset, sync clear wins over enable.
module flopenrc #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/alu_dec_mc_md_seq.sv
// Multiply/divide sequencer: IDLE/BUSY/DONE with a 6-bit down-counter.
module md_seq
   import alu_dec_mc_pkg::*;
#(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [1:0] op,
   output logic       busy,
   output logic       done
);

   localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);
   localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);

   seq_state_e state;
   logic [5:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= SeqIdle;
         cnt   <= '0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         unique case (state)
            SeqIdle, SeqDone: begin
               done <= 1'b0;
               if (start) begin
                  state <= SeqBusy;
                  cnt   <= op[1] ? DIV_LOAD : MUL_LOAD;
                  busy  <= 1'b1;
               end else begin
                  state <= SeqIdle;
                  busy  <= 1'b0;
               end
            end
            // Starts arriving here are ignored; D is stalled while BUSY.
            SeqBusy: begin
               if (cnt == 6'd0) begin
                  state <= SeqDone;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end
            default: begin
               state <= SeqIdle;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/alu_dec_mc.sv
// ALU decoder with E-stage registers and a multi-cycle mult/div sequencer.
module alu_dec_mc
   import alu_dec_mc_pkg::*;
#(
   parameter int unsigned ALUOP_W    = 8,
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 32
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [31:0]        instrD,
   input  logic               validD,
   input  logic               stallE,
   input  logic               flushE,
   output logic [ALUOP_W-1:0] aluopE,
   output logic               riE,
   output logic               md_startE,
   output logic [1:0]         md_opE,
   output logic               md_busy,
   output logic               md_done,
   output logic               stall_req
);

   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic [7:0]         aluop_d;
   logic               ri_d;
   logic               md_d;
   logic               hilo_d;
   md_op_e             md_op_d;
   logic               unused_instr;

   assign opcode       = instrD[31:26];
   assign funct        = instrD[5:0];
   assign unused_instr = ^instrD[25:6];

   always_comb begin
      aluop_d = ALUOP_NOP;
      ri_d    = 1'b0;
      md_d    = 1'b0;
      hilo_d  = 1'b0;
      md_op_d = MdMult;
      if (validD) begin
         case (opcode)
            OP_RTYPE: begin
               case (funct)
                  FN_ADD:   aluop_d = ALUOP_ADD;
                  FN_ADDU:  aluop_d = ALUOP_ADDU;
                  FN_SUB:   aluop_d = ALUOP_SUB;
                  FN_SUBU:  aluop_d = ALUOP_SUBU;
                  FN_AND:   aluop_d = ALUOP_AND;
                  FN_OR:    aluop_d = ALUOP_OR;
                  FN_XOR:   aluop_d = ALUOP_XOR;
                  FN_NOR:   aluop_d = ALUOP_NOR;
                  FN_SLT:   aluop_d = ALUOP_SLT;
                  FN_SLTU:  aluop_d = ALUOP_SLTU;
                  FN_SLL:   aluop_d = ALUOP_SLL;
                  FN_SRL:   aluop_d = ALUOP_SRL;
                  FN_SRA:   aluop_d = ALUOP_SRA;
                  FN_SLLV:  aluop_d = ALUOP_SLLV;
                  FN_SRLV:  aluop_d = ALUOP_SRLV;
                  FN_SRAV:  aluop_d = ALUOP_SRAV;
                  FN_JR, FN_JALR: aluop_d = ALUOP_NOP;
                  FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                     md_d    = 1'b1;
                     md_op_d = md_kind(funct);
                     unique case (md_kind(funct))
                        MdMult:  aluop_d = ALUOP_MULT;
                        MdMultu: aluop_d = ALUOP_MULTU;
                        MdDiv:   aluop_d = ALUOP_DIV;
                        MdDivu:  aluop_d = ALUOP_DIVU;
                        default: aluop_d = ALUOP_NOP;
                     endcase
                  end
                  FN_MFHI: begin aluop_d = ALUOP_MFHI; hilo_d = 1'b1; end
                  FN_MFLO: begin aluop_d = ALUOP_MFLO; hilo_d = 1'b1; end
                  FN_MTHI: begin aluop_d = ALUOP_MTHI; hilo_d = 1'b1; end
                  FN_MTLO: begin aluop_d = ALUOP_MTLO; hilo_d = 1'b1; end
                  default: ri_d = 1'b1;
               endcase
            end
            OP_ADDI:  aluop_d = ALUOP_ADD;
            OP_ADDIU: aluop_d = ALUOP_ADDU;
            OP_SLTI:  aluop_d = ALUOP_SLT;
            OP_SLTIU: aluop_d = ALUOP_SLTU;
            OP_ANDI:  aluop_d = ALUOP_AND;
            OP_ORI:   aluop_d = ALUOP_OR;
            OP_XORI:  aluop_d = ALUOP_XOR;
            OP_LUI:   aluop_d = ALUOP_LUI;
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW: aluop_d = ALUOP_ADD;
            OP_REGIMM, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: aluop_d = ALUOP_NOP;
            default: ri_d = 1'b1;
         endcase
      end
   end

   logic [ALUOP_W+2:0] e_d;
   logic [ALUOP_W+2:0] e_q;

   assign e_d = {ALUOP_W'(aluop_d), ri_d, md_op_d};

   flopenrc #(.WIDTH(ALUOP_W + 3)) u_e_regs (
      .clk (clk),
      .rst (rst),
      .en  (~stallE),
      .clr (flushE),
      .d   (e_d),
      .q   (e_q)
   );

   assign aluopE = e_q[ALUOP_W+2:3];
   assign riE    = e_q[2];
   assign md_opE = e_q[1:0];

   // The start pulse is never held: a stall or flush drops it.
   flopenrc #(.WIDTH(1)) u_start_reg (
      .clk (clk),
      .rst (rst),
      .en  (1'b1),
      .clr (flushE | stallE),
      .d   (md_d),
      .q   (md_startE)
   );

   md_seq #(
      .MUL_CYCLES (MUL_CYCLES),
      .DIV_CYCLES (DIV_CYCLES)
   ) u_md_seq (
      .clk   (clk),
      .rst   (rst),
      .start (md_startE),
      .op    (md_opE),
      .busy  (md_busy),
      .done  (md_done)
   );

   assign stall_req = (md_d | hilo_d) & (md_startE | md_busy);

endmodule

// File: tb/tb_alu_dec_mc.sv
// Bench for alu_dec_mc: cycle model compared every cycle plus directed literal checks.
module tb_alu_dec_mc;
   import alu_dec_mc_pkg::*;

   localparam int MULN = 4;
   localparam int DIVN = 32;

   typedef struct {
      logic [31:0] w;
      logic [7:0]  op;
      bit          ri;
      bit          md;
      logic [1:0]  kind;
      bit          hilo;
   } vec_t;

   localparam int V_ADDU = 0, V_DIV = 1, V_MFLO = 2, V_BAD = 3, V_MULT = 4, V_MULTU = 5,
                  V_DIVU = 6, V_ADDI = 7, V_LW = 8, V_BEQ = 9, V_ORI = 10, V_SUB = 11,
                  V_BADF = 12, V_MTHI = 13, V_LUI = 14, V_SW = 15, V_JAL = 16, V_SLTU = 17;

   vec_t vecs[18];

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [31:0] instrD;
   logic        validD = 1'b0;
   logic        stallE = 1'b0;
   logic        flushE = 1'b0;
   logic [7:0]  aluopE;
   logic        riE, md_startE, md_busy, md_done, stall_req;
   logic [1:0]  md_opE;
   int          cur_idx = V_ADDU;
   int          checks = 0;
   int          errors = 0;
   bit          chk_en = 1'b0;

   assign instrD = vecs[cur_idx].w;

   always #5 clk = ~clk;

   alu_dec_mc #(
      .ALUOP_W    (8),
      .MUL_CYCLES (MULN),
      .DIV_CYCLES (DIVN)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .instrD    (instrD),
      .validD    (validD),
      .stallE    (stallE),
      .flushE    (flushE),
      .aluopE    (aluopE),
      .riE       (riE),
      .md_startE (md_startE),
      .md_opE    (md_opE),
      .md_busy   (md_busy),
      .md_done   (md_done),
      .stall_req (stall_req)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: E stage as plain registers, sequencer as "busy cycles remaining".
   logic [7:0] m_aluop;
   logic       m_ri, m_start, m_done;
   logic [1:0] m_mdop;
   int         m_left;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_aluop <= '0; m_ri <= 1'b0; m_mdop <= '0; m_start <= 1'b0;
         m_left  <= 0;  m_done <= 1'b0;
      end else begin
         if (flushE) begin
            m_aluop <= '0; m_ri <= 1'b0; m_mdop <= '0; m_start <= 1'b0;
         end else if (stallE) begin
            m_start <= 1'b0;
         end else begin
            m_aluop <= validD ? vecs[cur_idx].op : 8'd0;
            m_ri    <= validD && vecs[cur_idx].ri;
            m_mdop  <= (validD && vecs[cur_idx].md) ? vecs[cur_idx].kind : 2'd0;
            m_start <= validD && vecs[cur_idx].md;
         end
         if (m_left > 0) begin
            m_left <= m_left - 1;
            m_done <= (m_left == 1);
         end else begin
            m_done <= 1'b0;
            if (m_start) m_left <= m_mdop[1] ? DIVN : MULN;
         end
      end
   end

   always @(negedge clk) begin
      if (rst && chk_en) begin
         chk("aluopE", 32'(aluopE), 32'(m_aluop));
         chk("riE", 32'(riE), 32'(m_ri));
         chk("md_opE", 32'(md_opE), 32'(m_mdop));
         chk("md_startE", 32'(md_startE), 32'(m_start));
         chk("md_busy", 32'(md_busy), 32'(m_left > 0));
         chk("md_done", 32'(md_done), 32'(m_done));
         chk("stall_req", 32'(stall_req), 32'(validD && (vecs[cur_idx].md || vecs[cur_idx].hilo)
                                               && (m_start || m_left > 0)));
      end
   end

   // Present inputs for one edge; returns 2 time units after that edge.
   task automatic step(input int idx, input bit v, input bit st, input bit fl);
      cur_idx = idx; validD = v; stallE = st; flushE = fl;
      @(posedge clk);
      #2;
   endtask

   task automatic count_busy(input int limit, output int n);
      n = 0;
      for (int i = 0; i < limit; i++) begin
         step(V_ADDU, 1'b0, 1'b0, 1'b0);
         if (md_busy) n++;
         if (md_done) break;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      vecs[V_ADDU]  = '{32'h00851021, ALUOP_ADDU,  0, 0, 2'd0, 0};
      vecs[V_DIV]   = '{32'h0085001A, ALUOP_DIV,   0, 1, 2'd2, 0};
      vecs[V_MFLO]  = '{32'h00001012, ALUOP_MFLO,  0, 0, 2'd0, 1};
      vecs[V_BAD]   = '{32'hFC000000, ALUOP_NOP,   1, 0, 2'd0, 0};
      vecs[V_MULT]  = '{32'h00850018, ALUOP_MULT,  0, 1, 2'd0, 0};
      vecs[V_MULTU] = '{32'h00850019, ALUOP_MULTU, 0, 1, 2'd1, 0};
      vecs[V_DIVU]  = '{32'h0085001B, ALUOP_DIVU,  0, 1, 2'd3, 0};
      vecs[V_ADDI]  = '{32'h20A50004, ALUOP_ADD,   0, 0, 2'd0, 0};
      vecs[V_LW]    = '{32'h8C820000, ALUOP_ADD,   0, 0, 2'd0, 0};
      vecs[V_BEQ]   = '{32'h10850003, ALUOP_NOP,   0, 0, 2'd0, 0};
      vecs[V_ORI]   = '{32'h34A5FFFF, ALUOP_OR,    0, 0, 2'd0, 0};
      vecs[V_SUB]   = '{32'h00851022, ALUOP_SUB,   0, 0, 2'd0, 0};
      vecs[V_BADF]  = '{32'h0085103F, ALUOP_NOP,   1, 0, 2'd0, 0};
      vecs[V_MTHI]  = '{32'h00800011, ALUOP_MTHI,  0, 0, 2'd0, 1};
      vecs[V_LUI]   = '{32'h3C051234, ALUOP_LUI,   0, 0, 2'd0, 0};
      vecs[V_SW]    = '{32'hAC820000, ALUOP_ADD,   0, 0, 2'd0, 0};
      vecs[V_JAL]   = '{32'h0C000000, ALUOP_NOP,   0, 0, 2'd0, 0};
      vecs[V_SLTU]  = '{32'h0085102B, ALUOP_SLTU,  0, 0, 2'd0, 0};

      // Reset state
      #3;
      chk("rst aluopE", 32'(aluopE), 0);
      chk("rst riE", 32'(riE), 0);
      chk("rst md_busy", 32'(md_busy), 0);
      chk("rst md_done", 32'(md_done), 0);
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b1;
      chk_en = 1'b1;

      // ADDU -> aluopE = 2 next edge
      step(V_ADDU, 1, 0, 0);
      chk("addu aluopE", 32'(aluopE), 32'd2);
      chk("addu riE", 32'(riE), 0);
      chk("addu md_startE", 32'(md_startE), 0);

      for (int i = V_ADDI; i <= V_SLTU; i++) step(i, 1, 0, 0);
      step(V_ORI, 1, 0, 0);
      chk("ori aluopE", 32'(aluopE), 32'd6);
      step(V_LW, 1, 0, 0);
      chk("lw aluopE", 32'(aluopE), 32'd1);

      // Reserved opcode, then the same word as a bubble
      step(V_BAD, 1, 0, 0);
      chk("ri riE", 32'(riE), 1);
      chk("ri aluopE", 32'(aluopE), 0);
      step(V_BAD, 0, 0, 0);
      chk("ri bubble riE", 32'(riE), 0);

      // DIV with MFLO waiting in D
      step(V_DIV, 1, 0, 0);
      chk("div md_startE", 32'(md_startE), 1);
      chk("div md_opE", 32'(md_opE), 2);
      chk("div aluopE", 32'(aluopE), 32'd20);
      cur_idx = V_MFLO;
      #1 chk("mflo stall at start", 32'(stall_req), 1);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(V_MFLO, 1, 0, 1);
         if (md_busy) begin
            n++;
            chk("mflo stall busy", 32'(stall_req), 1);
         end
         if (md_done) break;
      end
      chk("div busy cycles", 32'(n), 32'd32);
      chk("div done", 32'(md_done), 1);
      chk("mflo stall in done", 32'(stall_req), 0);
      step(V_MFLO, 1, 0, 0);
      chk("div done one cycle", 32'(md_done), 0);

      // Stall and flush together on MULT
      step(V_MULT, 1, 1, 1);
      chk("mult flush aluopE", 32'(aluopE), 0);
      chk("mult flush start", 32'(md_startE), 0);
      step(V_ADDU, 0, 0, 0);
      chk("mult flush idle", 32'(md_busy), 0);

      // Stall only: hold E, no start; then let MULT in
      step(V_ADDU, 1, 0, 0);
      step(V_MULT, 1, 1, 0);
      chk("stall hold aluopE", 32'(aluopE), 32'd2);
      chk("stall no start", 32'(md_startE), 0);
      step(V_MULT, 1, 0, 0);
      chk("mult start", 32'(md_startE), 1);
      count_busy(10, n);
      chk("mult busy cycles", 32'(n), 32'd4);

      // DIV then MULT entering E during DONE
      step(V_DIVU, 1, 0, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(V_ADDU, 0, 0, 0);
         if (md_busy) n++;
         if (n == 32) break;
      end
      step(V_MULT, 1, 0, 0);
      chk("b2b done", 32'(md_done), 1);
      chk("b2b start", 32'(md_startE), 1);
      count_busy(10, n);
      chk("b2b busy cycles", 32'(n), 32'd4);

      // Reset in BUSY at count 10
      step(V_DIV, 1, 0, 0);
      n = 0;
      for (int i = 0; i < 40; i++) begin
         step(V_ADDU, 0, 0, 0);
         if (md_busy) n++;
         if (n == 22) break;
      end
      #1 rst = 1'b0;
      #1;
      chk("arst aluopE", 32'(aluopE), 0);
      chk("arst riE", 32'(riE), 0);
      chk("arst md_opE", 32'(md_opE), 0);
      chk("arst md_startE", 32'(md_startE), 0);
      chk("arst md_busy", 32'(md_busy), 0);
      chk("arst md_done", 32'(md_done), 0);
      @(posedge clk); #2;
      rst = 1'b1;
      step(V_ADDU, 0, 0, 0);
      chk("arst no done", 32'(md_done), 0);
      step(V_MULTU, 1, 0, 0);
      chk("multu md_opE", 32'(md_opE), 1);
      count_busy(10, n);
      chk("multu busy cycles", 32'(n), 32'd4);
      step(V_MTHI, 1, 0, 0);
      step(V_ADDU, 0, 0, 0);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
